nonce_sweeper: RTL and testbench
================================

# nonce_sweeper

Mining controller on the issuing side of the double-SHA256 core. Latches an 80-byte header template, inserts successive nonces into the core's 640-bit block input, restarts the core per attempt via its reset, and compares each returned digest against a 256-bit target. It stops on the first hit, on range exhaustion, or on abort.

## Interface
- CORE_RST_CYCLES, 2: cycles `core_rst_n` is held low before each attempt (≥1).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- stop  in  1  abort request; wins over `start` in the same cycle.
- hdr_prefix  in  608  header bytes 0..75, byte 0 in [607:600]; latched on accepted start.
- nonce_start  in  32  first nonce tried; latched on accepted start.
- nonce_end  in  32  last nonce tried, inclusive; latched on accepted start.
- target  in  256  little-endian numeric target; latched on accepted start.
- core_rst_n  out  1  active-low reset to the hash core, registered.
- core_block  out  640  {hdr_prefix_q, bswap32(cur_nonce)}.
- core_hash  in  256  core digest {H0..H7}.
- core_done  in  1  core completion level.
- busy  out  1  high in RST, RUN and CHECK.
- found  out  1  level; hit recorded.
- exhausted  out  1  level; range finished with no hit.
- found_nonce  out  32  nonce of the hit.
- found_hash  out  256  byte-reversed digest of the hit, numeric big-endian form.
- cur_nonce  out  32  nonce under test.

## Operation
- States: IDLE, RST, RUN, CHECK.
- IDLE:
  - `core_rst_n` = 0.
  - On `start` && !`stop`: latch inputs, `cur_nonce` <= `nonce_start`, clear `found`/`exhausted`, rst counter <= 0, go to RST.
- RST:
  - `core_rst_n` = 0.
  - Counter increments each cycle. After CORE_RST_CYCLES cycles, go to RUN.
- RUN:
  - `core_rst_n` = 1.
  - On `core_done` = 1: capture hash_le = byte-reverse(`core_hash`) (core byte [255:248] becomes result [7:0]), go to CHECK.
- CHECK:
  - `core_rst_n` = 0.
  - If hash_le ≤ target (unsigned 256-bit): `found` <= 1, `found_nonce` <= `cur_nonce`, `found_hash` <= hash_le, go to IDLE.
  - Else if `cur_nonce` == `nonce_end`: `exhausted` <= 1, go to IDLE.
  - Else: `cur_nonce` <= `cur_nonce` + 1 (mod 2^32), go to RST.
- Range wrap: if `nonce_end` < `nonce_start`, the sweep passes through 0xFFFFFFFF → 0. Start 0, end 0xFFFFFFFF gives exactly 2^32 attempts. `nonce_start` == `nonce_end` gives one attempt.
- `stop` in any busy state: next state IDLE, `core_rst_n` low, `found`/`exhausted` unchanged (0). `cur_nonce` holds the aborted nonce.
- `start` while busy: ignored.
- `core_block` is stable whenever `core_rst_n` = 1, because `cur_nonce` changes only in CHECK.
- Reset values:
  - state IDLE; `core_rst_n` 0; `busy`, `found`, `exhausted` 0.
  - `found_nonce`, `cur_nonce` 0; `found_hash` 0; latched regs 0.
- `rst_n` mid-sweep: everything returns to reset values immediately; no result is reported.

## Timing
- All outputs are registered.
- Accepted start at edge N:
  - `busy` = 1 and `core_rst_n` = 0 from N.
  - `core_rst_n` rises at edge N+CORE_RST_CYCLES.
- `core_done` sampled high at edge M → CHECK at M. Result, increment, or re-reset decision at M+1.
- Per-attempt overhead beyond core latency: CORE_RST_CYCLES+2 cycles.
- `found`/`exhausted` rise in the same cycle `busy` falls. They hold until the next accepted start.
- `core_done` is ignored outside RUN.

## Test plan
- Genesis header (bytes 0..75 as `hdr_prefix`), target 0x00000000FFFF0000…0, nonce 0x7C2BAC1B..0x7C2BAC20, real core → `found`=1, `found_nonce`=0x7C2BAC1D after exactly 3 core restarts, `found_hash`=0x000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
- Same header, target 0, nonce 0x7C2BAC1B..0x7C2BAC1E → `exhausted`=1, `found`=0, 4 attempts, `cur_nonce`=0x7C2BAC1E.
- Stub core returning all-ones, start 0xFFFFFFFE, end 0x00000001 → nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 presented in order (`core_block`[31:0] byte-swapped), then `exhausted`.
- Stub core, `stop` asserted 3 cycles into second RUN → IDLE next cycle, `core_rst_n`=0, `found`=`exhausted`=0; a second `start` pulse during the sweep has no effect.
- Stub core with hash_le exactly equal to target → `found`=1 (≤ boundary). `start`+`stop` in the same cycle in IDLE → stays IDLE.
- `rst_n` pulsed low during RST and during RUN → all outputs at reset values; `core_rst_n` held 0 until the next `start`.

Source files
------------

// File: rtl/nonce_sweeper.sv
// nonce_sweeper: issues nonce attempts to a double-SHA256 core.
// Restarts the core per nonce and compares each digest to the target.
module nonce_sweeper #(
   parameter int CORE_RST_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         stop,
   input  logic [607:0] hdr_prefix,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   input  logic [255:0] target,
   output logic         core_rst_n,
   output logic [639:0] core_block,
   input  logic [255:0] core_hash,
   input  logic         core_done,
   output logic         busy,
   output logic         found,
   output logic         exhausted,
   output logic [31:0]  found_nonce,
   output logic [255:0] found_hash,
   output logic [31:0]  cur_nonce
);

   localparam int CW = (CORE_RST_CYCLES < 2) ? 1 : $clog2(CORE_RST_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(CORE_RST_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RST,
      RUN,
      CHECK
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [607:0]   hdr_q, hdr_d;
   logic [31:0]    nstart_q, nstart_d;
   logic [31:0]    nend_q, nend_d;
   logic [255:0]   target_q, target_d;
   logic [31:0]    cur_q, cur_d;
   logic [255:0]   hash_le_q, hash_le_d;
   logic           found_q, found_d;
   logic           exh_q, exh_d;
   logic [31:0]    fnonce_q, fnonce_d;
   logic [255:0]   fhash_q, fhash_d;
   logic           crst_n_q, crst_n_d;
   logic           busy_q, busy_d;

   // Core emits H0 first; numeric little-endian value needs full byte reversal.
   function automatic logic [255:0] bswap256(input logic [255:0] x);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) begin
         r[8*i +: 8] = x[255-8*i -: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hdr_d     = hdr_q;
      nstart_d  = nstart_q;
      nend_d    = nend_q;
      target_d  = target_q;
      cur_d     = cur_q;
      hash_le_d = hash_le_q;
      found_d   = found_q;
      exh_d     = exh_q;
      fnonce_d  = fnonce_q;
      fhash_d   = fhash_q;
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               hdr_d    = hdr_prefix;
               nstart_d = nonce_start;
               nend_d   = nonce_end;
               target_d = target;
               cur_d    = nonce_start;
               found_d  = 1'b0;
               exh_d    = 1'b0;
               cnt_d    = '0;
               state_d  = RST;
            end
         end
         RST: begin
            if (stop) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (core_done) begin
               hash_le_d = bswap256(core_hash);
               state_d   = CHECK;
            end
         end
         CHECK: begin
            if (stop) begin
               state_d = IDLE;
            end else if (hash_le_q <= target_q) begin
               found_d  = 1'b1;
               fnonce_d = cur_q;
               fhash_d  = hash_le_q;
               state_d  = IDLE;
            end else if (cur_q == nend_q) begin
               exh_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cur_d   = cur_q + 32'd1;
               cnt_d   = '0;
               state_d = RST;
            end
         end
         default: state_d = IDLE;
      endcase
      crst_n_d = (state_d == RUN);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hdr_q     <= '0;
         nstart_q  <= '0;
         nend_q    <= '0;
         target_q  <= '0;
         cur_q     <= '0;
         hash_le_q <= '0;
         found_q   <= 1'b0;
         exh_q     <= 1'b0;
         fnonce_q  <= '0;
         fhash_q   <= '0;
         crst_n_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hdr_q     <= hdr_d;
         nstart_q  <= nstart_d;
         nend_q    <= nend_d;
         target_q  <= target_d;
         cur_q     <= cur_d;
         hash_le_q <= hash_le_d;
         found_q   <= found_d;
         exh_q     <= exh_d;
         fnonce_q  <= fnonce_d;
         fhash_q   <= fhash_d;
         crst_n_q  <= crst_n_d;
         busy_q    <= busy_d;
      end
   end

   logic unused_nstart;
   assign unused_nstart = ^nstart_q;

   assign core_rst_n  = crst_n_q;
   assign core_block  = {hdr_q, bswap32(cur_q)};
   assign busy        = busy_q;
   assign found       = found_q;
   assign exhausted   = exh_q;
   assign found_nonce = fnonce_q;
   assign found_hash  = fhash_q;
   assign cur_nonce   = cur_q;

endmodule

// File: tb/tb_nonce_sweeper.sv
// tb_nonce_sweeper: directed tests with a stub hash core.
// Stub digest chosen per nonce so expected results are known up front.
module tb_nonce_sweeper;

   localparam int LAT = 4;
   localparam logic [255:0] GEN_LE =
      256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
   localparam logic [255:0] GEN_TGT = {32'h0, 16'hFFFF, 208'h0};
   localparam logic [255:0] EQ_TGT =
      256'h00000123456789abcdef00000000000000000000000000000000000000000042;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic [607:0] hdr_prefix = '0;
   logic [31:0]  nonce_start = '0;
   logic [31:0]  nonce_end = '0;
   logic [255:0] target = '0;
   logic         core_rst_n;
   logic [639:0] core_block;
   logic [255:0] core_hash;
   logic         core_done;
   logic         busy, found, exhausted;
   logic [31:0]  found_nonce, cur_nonce;
   logic [255:0] found_hash;

   int vec = 0;
   int errs = 0;
   int hmode = 0;
   int ccnt = 0;
   logic [31:0] seen[$];

   nonce_sweeper #(.CORE_RST_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .hdr_prefix(hdr_prefix), .nonce_start(nonce_start),
      .nonce_end(nonce_end), .target(target),
      .core_rst_n(core_rst_n), .core_block(core_block),
      .core_hash(core_hash), .core_done(core_done),
      .busy(busy), .found(found), .exhausted(exhausted),
      .found_nonce(found_nonce), .found_hash(found_hash),
      .cur_nonce(cur_nonce)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] bswap256(input logic [255:0] x);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
      return r;
   endfunction

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Stub core: done rises LAT cycles after release, drops on reset.
   always @(posedge clk) begin
      if (!core_rst_n) begin
         ccnt <= 0;
         core_done <= 1'b0;
      end else begin
         ccnt <= ccnt + 1;
         if (ccnt == LAT - 1) core_done <= 1'b1;
      end
   end

   always_comb begin
      core_hash = '1;
      if (hmode == 1 && bswap32(core_block[31:0]) == 32'h7C2BAC1D)
         core_hash = bswap256(GEN_LE);
      else if (hmode == 2)
         core_hash = bswap256(EQ_TGT);
   end

   always @(posedge core_rst_n) seen.push_back(core_block[31:0]);

   task automatic do_start(input logic [31:0] s, input logic [31:0] e,
                           input logic [255:0] t);
      @(negedge clk);
      nonce_start = s;
      nonce_end = e;
      target = t;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      vec++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL %s timeout: busy=%b required 0", nm, busy);
      end
   endtask

   task automatic test_reset();
      vec++;
      if ({busy, found, exhausted, core_rst_n} !== 4'b0) begin
         errs++;
         $display("FAIL reset_flags: got %b required 0000",
                  {busy, found, exhausted, core_rst_n});
      end
      vec++;
      if (cur_nonce !== 32'h0 || found_nonce !== 32'h0) begin
         errs++;
         $display("FAIL reset_nonce: cur=%h fnd=%h required 0", cur_nonce, found_nonce);
      end
      vec++;
      if (found_hash !== '0 || core_block !== '0) begin
         errs++;
         $display("FAIL reset_data: hash=%h required 0", found_hash);
      end
   endtask

   task automatic test_genesis();
      int base;
      hmode = 1;
      base = seen.size();
      do_start(32'h7C2BAC1B, 32'h7C2BAC20, GEN_TGT);
      vec++;
      if (busy !== 1'b1 || core_rst_n !== 1'b0) begin
         errs++;
         $display("FAIL start_N: busy=%b crst=%b required 1 0", busy, core_rst_n);
      end
      @(negedge clk);
      vec++;
      if (core_rst_n !== 1'b0) begin
         errs++;
         $display("FAIL start_N1: crst=%b required 0", core_rst_n);
      end
      @(negedge clk);
      vec++;
      if (core_rst_n !== 1'b1) begin
         errs++;
         $display("FAIL start_N2: crst=%b required 1", core_rst_n);
      end
      vec++;
      if (core_block[639:32] !== hdr_prefix) begin
         errs++;
         $display("FAIL block_hdr: got %h required %h", core_block[639:32], hdr_prefix);
      end
      wait_idle("genesis");
      vec++;
      if (found !== 1'b1 || exhausted !== 1'b0) begin
         errs++;
         $display("FAIL gen_flags: found=%b exh=%b required 1 0", found, exhausted);
      end
      vec++;
      if (found_nonce !== 32'h7C2BAC1D) begin
         errs++;
         $display("FAIL gen_nonce: got %h required 7c2bac1d", found_nonce);
      end
      vec++;
      if (found_hash !== GEN_LE) begin
         errs++;
         $display("FAIL gen_hash: got %h required %h", found_hash, GEN_LE);
      end
      vec++;
      if (seen.size() - base !== 3) begin
         errs++;
         $display("FAIL gen_attempts: got %0d required 3", seen.size() - base);
      end
   endtask

   task automatic test_exhaust();
      int base;
      hmode = 1;
      base = seen.size();
      do_start(32'h7C2BAC1B, 32'h7C2BAC1E, '0);
      wait_idle("exhaust");
      vec++;
      if (found !== 1'b0 || exhausted !== 1'b1) begin
         errs++;
         $display("FAIL exh_flags: found=%b exh=%b required 0 1", found, exhausted);
      end
      vec++;
      if (seen.size() - base !== 4 || cur_nonce !== 32'h7C2BAC1E) begin
         errs++;
         $display("FAIL exh_count: n=%0d cur=%h required 4 7c2bac1e",
                  seen.size() - base, cur_nonce);
      end
   endtask

   task automatic test_wrap();
      int base;
      logic [31:0] exp_raw[4];
      exp_raw = '{32'hFEFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h01000000};
      hmode = 0;
      base = seen.size();
      do_start(32'hFFFFFFFE, 32'h00000001, '0);
      wait_idle("wrap");
      vec++;
      if (seen.size() - base !== 4 || exhausted !== 1'b1) begin
         errs++;
         $display("FAIL wrap_count: n=%0d exh=%b required 4 1",
                  seen.size() - base, exhausted);
      end
      for (int i = 0; i < 4; i++) begin
         if (base + i < seen.size()) begin
            vec++;
            if (seen[base+i] !== exp_raw[i]) begin
               errs++;
               $display("FAIL wrap_block%0d: got %h required %h",
                        i, seen[base+i], exp_raw[i]);
            end
         end
      end
   endtask

   task automatic test_stop();
      int base;
      int n = 0;
      hmode = 0;
      base = seen.size();
      do_start(32'h100, 32'h200, '0);
      repeat (3) @(negedge clk);
      nonce_start = 32'h999;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (seen.size() < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      vec++;
      if (busy !== 1'b0 || core_rst_n !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0) begin
         errs++;
         $display("FAIL stop_state: busy=%b crst=%b f=%b e=%b required 0 0 0 0",
                  busy, core_rst_n, found, exhausted);
      end
      vec++;
      if (cur_nonce !== 32'h101 || seen.size() - base !== 2) begin
         errs++;
         $display("FAIL stop_nonce: cur=%h n=%0d required 101 2",
                  cur_nonce, seen.size() - base);
      end
      vec++;
      if (seen.size() >= base + 2 && seen[base] !== bswap32(32'h100)) begin
         errs++;
         $display("FAIL start_ignored: got %h required %h",
                  seen[base], bswap32(32'h100));
      end
   endtask

   task automatic test_equal();
      hmode = 2;
      do_start(32'h5, 32'h9, EQ_TGT);
      wait_idle("equal");
      vec++;
      if (found !== 1'b1 || found_nonce !== 32'h5 || found_hash !== EQ_TGT) begin
         errs++;
         $display("FAIL eq_hit: found=%b nonce=%h required 1 5", found, found_nonce);
      end
      @(negedge clk);
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      vec++;
      if (busy !== 1'b0 || core_rst_n !== 1'b0 || found !== 1'b1) begin
         errs++;
         $display("FAIL start_stop: busy=%b crst=%b found=%b required 0 0 1",
                  busy, core_rst_n, found);
      end
   endtask

   task automatic test_midreset();
      int n = 0;
      hmode = 0;
      do_start(32'h10, 32'h20, '0);
      #2 rst_n = 1'b0;
      #1;
      vec++;
      if ({busy, found, exhausted, core_rst_n} !== 4'b0 || cur_nonce !== 32'h0) begin
         errs++;
         $display("FAIL rst_in_rst: flags=%b cur=%h required 0000 0",
                  {busy, found, exhausted, core_rst_n}, cur_nonce);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      vec++;
      if (core_rst_n !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL rst_hold: crst=%b busy=%b required 0 0", core_rst_n, busy);
      end
      do_start(32'h10, 32'h20, '0);
      while (core_rst_n !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      vec++;
      if ({busy, found, exhausted, core_rst_n} !== 4'b0 ||
          found_hash !== '0 || core_block !== '0) begin
         errs++;
         $display("FAIL rst_in_run: flags=%b required 0000",
                  {busy, found, exhausted, core_rst_n});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      vec++;
      if (core_rst_n !== 1'b0) begin
         errs++;
         $display("FAIL rst_run_hold: crst=%b required 0", core_rst_n);
      end
   endtask

   initial begin
      for (int i = 0; i < 76; i++) hdr_prefix[8*i +: 8] = 8'(i * 7 + 3);
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_genesis();
      test_exhaust();
      test_wrap();
      test_stop();
      test_equal();
      test_midreset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
